// File: rtl/hft_pkg.sv
// Shared types and constants for the order transmit path.
package hft_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef struct packed {
    logic                  side;
    logic [DATA_W_DEF-1:0] price;
    logic [DATA_W_DEF-1:0] vol;
  } order_t;

  typedef enum logic {IDLE, SEND} tx_state_t;

endpackage

// File: rtl/tx_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_STOCKS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_STOCKS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NUM_STOCKS-1:0] gnt,
  output logic [IDX_W-1:0]      gnt_idx
);

  int         j;
  logic       found;
  logic [IDX_W-1:0] jj;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NUM_STOCKS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_STOCKS) j = j - NUM_STOCKS;
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/tx_mux.sv
// Funnels per-stock order slots into one valid/ready order stream, round-robin.
// Optional TX_MUX_STATS_EN adds saturating sent/drop counters.
module tx_mux
  import hft_pkg::*;
#(
  parameter int NUM_STOCKS = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_STOCKS-1:0]        ord_dv,
  input  logic [NUM_STOCKS-1:0]        ord_side,
  input  logic [NUM_STOCKS*DATA_W-1:0] ord_price,
  input  logic [NUM_STOCKS*DATA_W-1:0] ord_vol,
  output logic [NUM_STOCKS-1:0]        ord_full,
  output logic [NUM_STOCKS-1:0]        ord_ovf,
  output logic [ADDR_W-1:0]            tx_addr,
  output logic                         tx_side,
  output logic [DATA_W-1:0]            tx_price,
  output logic [DATA_W-1:0]            tx_vol,
  output logic                         tx_dv,
  input  logic                         tx_ready
`ifdef TX_MUX_STATS_EN
  ,
  output logic [15:0]                  sent_cnt,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int IDX_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  tx_state_t             state, state_nxt;
  logic [NUM_STOCKS-1:0] full_q, ovf_q, arb_gnt, free_vec, cap_vec, drop_vec;
  logic [IDX_W-1:0]      rr_ptr, grant_q, arb_idx;
  logic                  accept;

  logic                  slot_side  [NUM_STOCKS];
  logic [DATA_W-1:0]     slot_price [NUM_STOCKS];
  logic [DATA_W-1:0]     slot_vol   [NUM_STOCKS];

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == NUM_STOCKS - 1) return '0;
    return g + IDX_W'(1);
  endfunction

  rr_arbiter #(.NUM_STOCKS(NUM_STOCKS), .IDX_W(IDX_W)) u_arb (
    .req     (full_q),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign accept   = (state == SEND) && tx_ready;
  assign tx_dv    = (state == SEND);
  assign ord_full = full_q;
  assign ord_ovf  = ovf_q;

  // A slot being accepted this cycle counts as empty for an incoming strobe
  always_comb begin
    free_vec = '0;
    if (accept) free_vec[grant_q] = 1'b1;
  end

  assign cap_vec  = ord_dv & (~full_q | free_vec);
  assign drop_vec = ord_dv & full_q & ~free_vec;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|arb_gnt) state_nxt = SEND;
      SEND:    if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      full_q   <= '0;
      ovf_q    <= '0;
      rr_ptr   <= '0;
      grant_q  <= '0;
      tx_addr  <= '0;
      tx_side  <= 1'b0;
      tx_price <= '0;
      tx_vol   <= '0;
    end else begin
      state  <= state_nxt;
      full_q <= (full_q & ~free_vec) | cap_vec;
      ovf_q  <= ovf_q | drop_vec;
      if (state == IDLE && |arb_gnt) begin
        grant_q  <= arb_idx;
        tx_addr  <= ADDR_W'(arb_idx);
        tx_side  <= slot_side[arb_idx];
        tx_price <= slot_price[arb_idx];
        tx_vol   <= slot_vol[arb_idx];
      end
      if (accept) rr_ptr <= next_ptr(grant_q);
    end
  end

  // Slot payload needs no reset; occupancy is tracked by full_q
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_STOCKS; i++) begin
      if (cap_vec[i]) begin
        slot_side[i]  <= ord_side[i];
        slot_price[i] <= ord_price[i*DATA_W +: DATA_W];
        slot_vol[i]   <= ord_vol[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef TX_MUX_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input int unsigned b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      sent_cnt <= sat_add(sent_cnt, accept ? 1 : 0);
      drop_cnt <= sat_add(drop_cnt, $countones(drop_vec));
    end
  end
`endif

endmodule
